alu_seq_ctrl: RTL
=================

// Module: alu_seq_ctrl
// PURPOSE
//  Sequencer in front of the external combinational Hack ALU (x,y,zx,nx,zy,ny,f,no -> out,zr,ng).
//  Accepts one request at a time: either a raw single ALU op or a 16x16 multiply (low 16 bits).
//  The multiply is built from repeated ALU add/double steps.
//  Sits between the CPU control/requester and the ALU instance, and owns all ALU inputs.
// PARAMETERS
//  DATA_W     16          datapath width; only 16 is supported (matches ALU)
//  IDLE_CTRL  6'b101010   {zx,nx,zy,ny,f,no} driven when ALU is unused (constant 0)
// PORTS
//  clk        in   1   clock, rising edge
//  rst_n      in   1   asynchronous, active-low reset
//  req_valid  in   1   request present
//  req_ready  out  1   controller can accept (= state==IDLE)
//  req_op     in   1   0 = raw ALU op, 1 = multiply
//  req_ctrl   in   6   {zx,nx,zy,ny,f,no} for raw op; ignored for multiply
//  req_a      in   16  operand x / multiplicand
//  req_b      in   16  operand y / multiplier
//  rsp_valid  out  1   result available, held until rsp_ready
//  rsp_ready  in   1   consumer accepts result
//  rsp_data   out  16  result
//  rsp_zr     out  1   rsp_data==0
//  rsp_ng     out  1   rsp_data[15]
//  alu_x/alu_y                                 out  16 each  ALU operands
//  alu_zx,alu_nx,alu_zy,alu_ny,alu_f,alu_no    out  1 each   ALU control
//  alu_out    in   16  ALU result
//  alu_zr     in   1   ALU zero flag
//  alu_ng     in   1   ALU negative flag
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE; acc,m,b,rsp_data=0; rsp_zr=rsp_ng=rsp_valid=0.
//    req_ready=1; ALU driven x=y=0, ctrl=IDLE_CTRL. An op in flight is aborted and no response is produced.
//  - States: IDLE, EXEC, ADD, DBL, RESP. Accept edge E0 = req_valid&&req_ready.
//  - IDLE at E0:
//    - raw -> EXEC, latching a, b, ctrl.
//    - mul with b==0 -> RESP (data=0, zr=1, ng=0).
//    - mul with b[0]=1 -> ADD; otherwise -> DBL. Both latch m=a, b, acc=0.
//  - EXEC: ALU x=a, y=b, ctrl=latched ctrl. Next edge: rsp_* <= alu_out/zr/ng; -> RESP.
//  - ADD: x=acc, y=m, ctrl=000010 (x+y); acc<=alu_out.
//    - If b[15:1]==0: rsp_* <= alu_out/zr/ng; -> RESP.
//    - Otherwise -> DBL.
//  - DBL: x=y=m, ctrl=000010; m<=alu_out; b<=b>>1; next is ADD if new b[0]=1, else DBL.
//  - Arithmetic is modulo 2^16 (ALU wraps). The product is unsigned low 16 bits, which are identical for signed operands.
//  - Latency: rsp_valid rises at edge E_N after E0.
//    - raw: N=1. mul b==0: N=0.
//    - mul otherwise: N = popcount(b) + index_of_msb(b). Examples: b=1 -> 1; 0x8000 -> 16; 0xFFFF -> 31.
//  - RESP: rsp_valid=1, rsp_* stable until rsp_valid&&rsp_ready, then -> IDLE. There is no same-cycle re-accept.
//  - req_valid while not IDLE is ignored (req_ready=0). Request inputs are sampled only at E0.
//  - ALU inputs outside EXEC/ADD/DBL: x=y=0, ctrl=IDLE_CTRL.
//  - rsp_data/zr/ng keep their last value after handshake until the next result is written.
// CONFIGURATION
//  ALU_MUL_OVF_EN defined:
//    - Adds port `rsp_ovf out 1`, valid with rsp_valid.
//    - Set for a multiply if any ADD wraps (alu_out < acc, unsigned) or any DBL sees m[15]=1, i.e. true product >= 2^16.
//    - Cleared at E0. Always 0 for raw ops and for b==0.
//  ALU_MUL_OVF_EN undefined: port and overflow logic are absent; all else identical.
// TESTING
//  1 Raw req_ctrl=000010, a=0x1234, b=0x5678 -> rsp_data=0x68AC, zr=0, ng=0; rsp_valid at E1.
//  2 Raw req_ctrl=010011 (x-y), a=0x0001, b=0x0002 -> 0xFFFF, ng=1.
//  3 Mul 0x0003*0x0005 -> 0x000F; ADD,DBL,DBL,ADD; rsp_valid at E4. Mul 0x1234*0x0000 -> 0x0000, zr=1, rsp_valid at E0.
//  4 Mul 0xFFFF*0xFFFF -> 0x0001, rsp_valid at E31, ovf=1 (if EN).
//    Mul 0x00FF*0x0100 -> 0xFF00, ng=1, ovf=0.
//  5 Backpressure: rsp_ready=0 for 5 cycles -> rsp_* stable, req_ready=0, new req_valid ignored.
//    Then rsp_ready=1 -> IDLE and req_ready=1 the next cycle.
//  6 rst_n pulsed low during DBL of 0xFFFF*0xFFFF -> rsp_valid=0 and req_ready=1 immediately.
//    No response after release; next raw request completes normally.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// Request sequencer that owns the inputs of an external Hack ALU: one raw op, or a 16x16 shift-add multiply.
// Optional overflow reporting (rsp_ovf) is compiled in when ALU_MUL_OVF_EN is defined.
module alu_seq_ctrl #(
    parameter int         DATA_W    = 16,
    parameter logic [5:0] IDLE_CTRL = 6'b101010
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_op,
    input  logic [5:0]        req_ctrl,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_zr,
    output logic              rsp_ng,
`ifdef ALU_MUL_OVF_EN
    output logic              rsp_ovf,
`endif
    output logic [DATA_W-1:0] alu_x,
    output logic [DATA_W-1:0] alu_y,
    output logic              alu_zx,
    output logic              alu_nx,
    output logic              alu_zy,
    output logic              alu_ny,
    output logic              alu_f,
    output logic              alu_no,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_zr,
    input  logic              alu_ng
);

    localparam logic [5:0] ADD_CTRL = 6'b000010;

    typedef enum logic [2:0] {S_IDLE, S_EXEC, S_ADD, S_DBL, S_RESP} state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] acc, m, b;
    logic [5:0]        ctrl_q;
    logic [5:0]        alu_ctrl;
    logic              accept;
    logic              last_add;

    assign req_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_RESP);
    assign accept    = req_valid && req_ready;
    // The final ADD is the one with no higher multiplier bits left to consume.
    assign last_add  = (b[DATA_W-1:1] == '0);

    assign {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = alu_ctrl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
        state_nxt = state;
        alu_x     = '0;
        alu_y     = '0;
        alu_ctrl  = IDLE_CTRL;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (!req_op)           state_nxt = S_EXEC;
                    else if (req_b == '0)  state_nxt = S_RESP;
                    else if (req_b[0])     state_nxt = S_ADD;
                    else                   state_nxt = S_DBL;
                end
            end
            S_EXEC: begin
                alu_x     = m;
                alu_y     = b;
                alu_ctrl  = ctrl_q;
                state_nxt = S_RESP;
            end
            S_ADD: begin
                alu_x     = acc;
                alu_y     = m;
                alu_ctrl  = ADD_CTRL;
                state_nxt = last_add ? S_RESP : S_DBL;
            end
            S_DBL: begin
                alu_x     = m;
                alu_y     = m;
                alu_ctrl  = ADD_CTRL;
                state_nxt = b[1] ? S_ADD : S_DBL;
            end
            S_RESP: begin
                if (rsp_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // m doubles as the raw x operand so both request kinds share one latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            m        <= '0;
            b        <= '0;
            ctrl_q   <= '0;
            rsp_data <= '0;
            rsp_zr   <= 1'b0;
            rsp_ng   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        m      <= req_a;
                        b      <= req_b;
                        acc    <= '0;
                        ctrl_q <= req_ctrl;
                        if (req_op && req_b == '0) begin
                            rsp_data <= '0;
                            rsp_zr   <= 1'b1;
                            rsp_ng   <= 1'b0;
                        end
                    end
                end
                S_EXEC: begin
                    rsp_data <= alu_out;
                    rsp_zr   <= alu_zr;
                    rsp_ng   <= alu_ng;
                end
                S_ADD: begin
                    acc <= alu_out;
                    if (last_add) begin
                        rsp_data <= alu_out;
                        rsp_zr   <= alu_zr;
                        rsp_ng   <= alu_ng;
                    end
                end
                S_DBL: begin
                    m <= alu_out;
                    b <= b >> 1;
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_MUL_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE:  if (accept) ovf_q <= 1'b0;
                S_ADD:   if (alu_out < acc) ovf_q <= 1'b1;
                S_DBL:   if (m[DATA_W-1]) ovf_q <= 1'b1;
                default: ;
            endcase
        end
    end

    assign rsp_ovf = ovf_q;
`endif

endmodule
